object_draw_seq: RTL
====================

Name: object_draw_seq

Overview:
- Parametrised successor of the single-pixel object draw sequencer.
- For each object ID in a contiguous range, it:
  - reads the object's X and Y from memory through the shared datapath handshake;
  - issues one DRAW instruction per pixel of a SPRITE_W x SPRITE_H block.
- Supports draw and erase modes, clipping at the screen edge, and skipping dead objects.
- Sits between the game-loop controller (start/finished) and the datapath arbiter (start_dp/finished_dp).

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.
- ADDR_W, 8, memory address / object ID width.
- RESULT_W, 16, datapath result width.
- INSTR_W, 32, instruction width.
- OPCODE_W, 4, opcode field width.
- OP_MEMREAD, 1, memory-read opcode.
- OP_DRAW, 2, draw opcode.
- SPRITE_W, 2, sprite width in pixels (1..2^X_W-1).
- SPRITE_H, 2, sprite height in pixels (1..2^Y_W-1).
- SCREEN_W, 160, pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, pixels with y >= SCREEN_H are clipped.
- DEAD_X, 2^X_W-1, an x value equal to this marks the object dead.

Ports:
- clock, in, 1, clock.
- resetn, in, 1, synchronous active-low reset.
- start, in, 1, request a pass; sampled only in IDLE.
- first_id, in, ADDR_W, first object ID; sampled with start.
- count, in, ADDR_W, number of objects; sampled with start.
- base_x, in, ADDR_W, base address of the X table; sampled with start.
- base_y, in, ADDR_W, base address of the Y table; sampled with start.
- colour, in, COLOUR_W, draw colour; sampled with start.
- erase, in, 1, selects erase mode (draw colour 0); sampled with start.
- finished, out, 1, high when idle.
- start_dp, out, 1, datapath request.
- instruction_dp, out, INSTR_W, datapath instruction.
- finished_dp, in, 1, datapath done.
- result_dp, in, RESULT_W, datapath read data.
- pixels_drawn, out, 16, count of DRAW instructions in the current/last pass.

Behaviour:
- Reset (resetn low at a clock edge):
  - state goes to IDLE;
  - finished=1, start_dp=0, instruction_dp=0, pixels_drawn=0;
  - all internal registers are zeroed.
  - Reset mid-transaction aborts immediately; no further start_dp pulse is issued.
- All outputs are registered.
- States: IDLE, RDX_ISSUE, RDX_HOLD, RDX_WAIT, RDY_ISSUE, RDY_HOLD, RDY_WAIT, PX_CHECK, PX_ISSUE, PX_HOLD, PX_WAIT, NEXT_OBJ.
- IDLE:
  - finished=1.
  - When start=1: latch the inputs, set id=first_id, clear pixels_drawn, set finished=0 on the next cycle.
  - If count=0, go to NEXT_OBJ so finished is low for exactly 2 cycles; otherwise go to RDX_ISSUE.
- Transaction rules (every datapath access):
  - start_dp is high for exactly 2 consecutive cycles (ISSUE, HOLD).
  - instruction_dp changes only in the first of those cycles and holds until the next ISSUE.
  - In WAIT, start_dp=0; the block advances on the first cycle with finished_dp=1.
  - finished_dp is ignored in ISSUE/HOLD.
- Memory reads:
  - instruction_dp = zero-extend {addr, OP_MEMREAD}, with the opcode in bits [OPCODE_W-1:0].
  - X read uses addr = base_x + id; Y read uses addr = base_y + id; both mod 2^ADDR_W.
  - x takes result_dp[X_W-1:0] and y takes result_dp[Y_W-1:0]; upper bits are discarded.
- Dead object: after RDX_WAIT, if x==DEAD_X, skip the Y read and pixels and go to NEXT_OBJ.
- Pixel loop:
  - dx and dy start at 0; raster order with dx fastest.
  - px = x+dx, py = y+dy, computed at X_W+1 and Y_W+1 bits (no wrap).
- PX_CHECK:
  - If px >= SCREEN_W or py >= SCREEN_H, the pixel is clipped: no transaction, 1 cycle.
  - Otherwise go to PX_ISSUE with instruction_dp = zero-extend {1'b1, c, py[Y_W-1:0], px[X_W-1:0], OP_DRAW}, where c = erase ? 0 : colour.
- PX_WAIT: on the first cycle with finished_dp=1, increment pixels_drawn (saturating at 0xFFFF).
- After each pixel (drawn or clipped): advance dx/dy; after the last pixel, go to NEXT_OBJ.
- NEXT_OBJ:
  - Decrement remaining; id increments mod 2^ADDR_W.
  - If remaining reaches 0 (or count was 0), go to IDLE; otherwise go to RDX_ISSUE.
- start asserted while busy is ignored; inputs may change freely while busy.
- result_dp is captured only in the RD*_WAIT states.

Test Plan:
- Single object, zero-wait datapath:
  - Stimulus: count=1, id=5, base_x=0x10, base_y=0x20, X=3, Y=4, colour=6, 2x2 sprite.
  - Response: reads of 0x15 then 0x25; DRAW at (3,4),(4,4),(3,5),(4,5) with colour 6; pixels_drawn=4; finished returns to 1.
- Datapath latency:
  - Stimulus: finished_dp delayed 7 cycles on each transaction.
  - Response: start_dp is exactly 2 cycles per transaction; no early advance; a finished_dp pulse during ISSUE/HOLD is ignored.
- Clipping and erase:
  - Stimulus: X=159, Y=119, erase=1.
  - Response: only one DRAW at (159,119) with colour 0; pixels_drawn=1.
- Dead object and wrap:
  - Stimulus: count=3, first_id=0xFF, middle object has X=0xFF.
  - Response: IDs 0xFF, 0x00, 0x01 are read; the dead object gets no Y read and no draws; pixels_drawn=8.
- count=0 and busy-start:
  - Stimulus: count=0; then a start pulse while busy.
  - Response: count=0 gives no start_dp and finished low for exactly 2 cycles; the busy-time start is ignored.
- Reset mid-PX_WAIT:
  - Stimulus: resetn low during PX_WAIT.
  - Response: next cycle finished=1, start_dp=0, instruction_dp=0, pixels_drawn=0.

Source files
------------

// File: rtl/object_draw_seq_if.sv
// Datapath handshake between the object draw sequencer and the datapath arbiter.
interface object_draw_seq_if #(
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 16
);
  logic                start_dp;
  logic [INSTR_W-1:0]  instruction_dp;
  logic                finished_dp;
  logic [RESULT_W-1:0] result_dp;

  modport master (output start_dp, output instruction_dp, input finished_dp, input result_dp);
  modport slave  (input start_dp, input instruction_dp, output finished_dp, output result_dp);
endinterface

// File: rtl/object_draw_seq.sv
// Walks a contiguous range of object IDs, reads each object's X/Y through the datapath
// and issues one clipped DRAW per pixel of a SPRITE_W x SPRITE_H block.
module object_draw_seq #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int ADDR_W     = 8,
  parameter int RESULT_W   = 16,
  parameter int INSTR_W    = 32,
  parameter int OPCODE_W   = 4,
  parameter int OP_MEMREAD = 1,
  parameter int OP_DRAW    = 2,
  parameter int SPRITE_W   = 2,
  parameter int SPRITE_H   = 2,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int DEAD_X     = (1 << X_W) - 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   first_id,
  input  logic [ADDR_W-1:0]   count,
  input  logic [ADDR_W-1:0]   base_x,
  input  logic [ADDR_W-1:0]   base_y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                erase,
  output logic                finished,
  output logic [15:0]         pixels_drawn,
  object_draw_seq_if.master   dp
);

  typedef enum logic [3:0] {
    IDLE, RDX_ISSUE, RDX_HOLD, RDX_WAIT, RDY_ISSUE, RDY_HOLD, RDY_WAIT,
    PX_CHECK, PX_ISSUE, PX_HOLD, PX_WAIT, NEXT_OBJ
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   id_reg, id_next, remaining_reg, remaining_next;
  logic [ADDR_W-1:0]   base_x_reg, base_x_next, base_y_reg, base_y_next;
  logic [COLOUR_W-1:0] colour_reg, colour_next;
  logic [X_W-1:0]      x_reg, x_next, dx_reg, dx_next;
  logic [Y_W-1:0]      y_reg, y_next, dy_reg, dy_next;
  logic [15:0]         pixels_reg, pixels_next;
  logic                finished_reg, finished_next, start_dp_reg, start_dp_next;
  logic [INSTR_W-1:0]  instr_reg, instr_next;

  logic [X_W:0]        px;
  logic [Y_W:0]        py;
  logic                clipped;
  state_t              adv_state;
  logic [X_W-1:0]      adv_dx;
  logic [Y_W-1:0]      adv_dy;

  // Extra top bit keeps x+dx from wrapping back onto the visible screen.
  assign px      = {1'b0, x_reg} + {1'b0, dx_reg};
  assign py      = {1'b0, y_reg} + {1'b0, dy_reg};
  assign clipped = (px >= (X_W+1)'(SCREEN_W)) || (py >= (Y_W+1)'(SCREEN_H));

  // Raster step shared by clipped and drawn pixels.
  always_comb begin
    adv_state = PX_CHECK;
    adv_dx    = dx_reg + X_W'(1);
    adv_dy    = dy_reg;
    if (dx_reg == X_W'(SPRITE_W - 1)) begin
      adv_dx = '0;
      adv_dy = dy_reg + Y_W'(1);
      if (dy_reg == Y_W'(SPRITE_H - 1)) begin
        adv_dy    = '0;
        adv_state = NEXT_OBJ;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    id_next        = id_reg;
    remaining_next = remaining_reg;
    base_x_next    = base_x_reg;
    base_y_next    = base_y_reg;
    colour_next    = colour_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    pixels_next    = pixels_reg;
    instr_next     = instr_reg;

    case (state_reg)
      IDLE: if (start) begin
        id_next        = first_id;
        remaining_next = count;
        base_x_next    = base_x;
        base_y_next    = base_y;
        colour_next    = erase ? '0 : colour;
        pixels_next    = '0;
        state_next     = (count == '0) ? NEXT_OBJ : RDX_ISSUE;
      end
      RDX_ISSUE: state_next = RDX_HOLD;
      RDX_HOLD:  state_next = RDX_WAIT;
      RDX_WAIT: if (dp.finished_dp) begin
        x_next     = dp.result_dp[X_W-1:0];
        state_next = (dp.result_dp[X_W-1:0] == X_W'(DEAD_X)) ? NEXT_OBJ : RDY_ISSUE;
      end
      RDY_ISSUE: state_next = RDY_HOLD;
      RDY_HOLD:  state_next = RDY_WAIT;
      RDY_WAIT: if (dp.finished_dp) begin
        y_next     = dp.result_dp[Y_W-1:0];
        dx_next    = '0;
        dy_next    = '0;
        state_next = PX_CHECK;
      end
      PX_CHECK: begin
        if (clipped) begin
          dx_next    = adv_dx;
          dy_next    = adv_dy;
          state_next = adv_state;
        end else begin
          state_next = PX_ISSUE;
        end
      end
      PX_ISSUE: state_next = PX_HOLD;
      PX_HOLD:  state_next = PX_WAIT;
      PX_WAIT: if (dp.finished_dp) begin
        if (pixels_reg != 16'hFFFF) pixels_next = pixels_reg + 16'd1;
        dx_next    = adv_dx;
        dy_next    = adv_dy;
        state_next = adv_state;
      end
      NEXT_OBJ: begin
        id_next = id_reg + ADDR_W'(1);
        if (remaining_reg <= ADDR_W'(1)) begin
          remaining_next = '0;
          state_next     = IDLE;
        end else begin
          remaining_next = remaining_reg - ADDR_W'(1);
          state_next     = RDX_ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase

    // The instruction is loaded only on entry to an ISSUE state and then held.
    if (state_next == RDX_ISSUE && state_reg != RDX_ISSUE)
      instr_next = INSTR_W'({ADDR_W'(base_x_next + id_next), OPCODE_W'(OP_MEMREAD)});
    else if (state_next == RDY_ISSUE && state_reg != RDY_ISSUE)
      instr_next = INSTR_W'({ADDR_W'(base_y_reg + id_reg), OPCODE_W'(OP_MEMREAD)});
    else if (state_next == PX_ISSUE && state_reg != PX_ISSUE)
      instr_next = INSTR_W'({1'b1, colour_reg, py[Y_W-1:0], px[X_W-1:0], OPCODE_W'(OP_DRAW)});
  end

  assign start_dp_next = (state_next == RDX_ISSUE) || (state_next == RDX_HOLD) ||
                         (state_next == RDY_ISSUE) || (state_next == RDY_HOLD) ||
                         (state_next == PX_ISSUE)  || (state_next == PX_HOLD);
  // Lags the return to IDLE by one cycle, so an empty pass still shows two busy cycles.
  assign finished_next = (state_reg == IDLE) && !start;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      remaining_reg <= '0;
      base_x_reg    <= '0;
      base_y_reg    <= '0;
      colour_reg    <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      pixels_reg    <= '0;
      finished_reg  <= 1'b1;
      start_dp_reg  <= 1'b0;
      instr_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      id_reg        <= id_next;
      remaining_reg <= remaining_next;
      base_x_reg    <= base_x_next;
      base_y_reg    <= base_y_next;
      colour_reg    <= colour_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      pixels_reg    <= pixels_next;
      finished_reg  <= finished_next;
      start_dp_reg  <= start_dp_next;
      instr_reg     <= instr_next;
    end
  end

  assign finished           = finished_reg;
  assign pixels_drawn       = pixels_reg;
  assign dp.start_dp        = start_dp_reg;
  assign dp.instruction_dp  = instr_reg;

endmodule
